mips_debug_controller: RTL and testbench

UART-driven debug controller between the UART byte interface and the MIPS pipeline; second-generation debug unit. It replaces gated-clock control with a clock-enable, and implements program load into instruction memory, a single PC breakpoint, and pause/resume. It also generalises word width, register-file depth and data-memory dump depth. Every stop (halt, breakpoint, step) emits a state dump: PC, cycle count, registers, then data-memory words, each word MSB-first.

---
 rtl/mips_debug_controller.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mips_debug_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_controller.sv
// UART debug controller for the MIPS core: program load, PC breakpoint, run/pause/step,
// and a full state dump (PC, cycles, registers, data memory) after every stop.
module mips_debug_controller #(
    parameter int DATA_BITS  = 8,
    parameter int WORD_BITS  = 32,
    parameter int REG_COUNT  = 32,
    parameter int MEM_WORDS  = 16,
    parameter int IMEM_WORDS = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_rx_valid,
    input  logic [DATA_BITS-1:0]          i_rx_data,
    input  logic                          i_tx_busy,
    output logic                          o_tx_start,
    output logic [DATA_BITS-1:0]          o_tx_data,
    input  logic                          i_mips_halt,
    input  logic [WORD_BITS-1:0]          i_mips_pc,
    input  logic [WORD_BITS-1:0]          i_mips_cycles,
    input  logic [WORD_BITS-1:0]          i_mips_reg_data,
    input  logic [WORD_BITS-1:0]          i_mips_mem_data,
    output logic [$clog2(REG_COUNT)-1:0]  o_mips_reg_addr,
    output logic [$clog2(MEM_WORDS)-1:0]  o_mips_mem_addr,
    output logic                          o_mips_enable,
    output logic                          o_mips_reset,
    output logic                          o_imem_we,
    output logic [$clog2(IMEM_WORDS)-1:0] o_imem_addr,
    output logic [WORD_BITS-1:0]          o_imem_data,
    output logic [3:0]                    o_state
);
    localparam int BPW   = WORD_BITS / DATA_BITS;
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TOTAL = 2 + REG_COUNT + MEM_WORDS;
    localparam int WI_W  = $clog2(TOTAL);
    localparam int RA_W  = $clog2(REG_COUNT);
    localparam int MA_W  = $clog2(MEM_WORDS);
    localparam int IA_W  = $clog2(IMEM_WORDS);

    localparam logic [3:0] S_IDLE = 4'd0, S_LOAD_LEN = 4'd1, S_LOAD_DATA = 4'd2,
                           S_BRK_DATA = 4'd3, S_RUN = 4'd4, S_PAUSE = 4'd5,
                           S_STEP_EXEC = 4'd6, S_DUMP_READ = 4'd7, S_DUMP_TX = 4'd8,
                           S_DUMP_WAIT = 4'd9;

    localparam logic [DATA_BITS-1:0] CMD_R = DATA_BITS'('h72), CMD_S = DATA_BITS'('h73),
                                     CMD_L = DATA_BITS'('h6C), CMD_B = DATA_BITS'('h62),
                                     CMD_C = DATA_BITS'('h63), CMD_N = DATA_BITS'('h6E),
                                     CMD_Q = DATA_BITS'('h71);

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BPW - 1);
    localparam logic [WI_W-1:0] WI_LAST = WI_W'(TOTAL - 1);
    localparam logic [WI_W-1:0] REG_LO  = WI_W'(2);
    localparam logic [WI_W-1:0] REG_HI  = WI_W'(2 + REG_COUNT - 1);
    localparam logic [WI_W-1:0] MEM_LO  = WI_W'(2 + REG_COUNT);

    logic [3:0]           state_q, state_d;
    logic [BC_W-1:0]      bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] cnt_q, cnt_d;
    logic [DATA_BITS-1:0] len_q, len_d;
    logic [WORD_BITS-1:0] sh_q, sh_d;
    logic [WORD_BITS-1:0] brk_addr_q, brk_addr_d;
    logic                 bp_valid_q, bp_valid_d;
    logic                 skip_q, skip_d;
    logic                 halt_stop_q, halt_stop_d;
    logic                 rd_phase_q, rd_phase_d;
    logic                 wait_ign_q, wait_ign_d;
    logic [WI_W-1:0]      widx_q, widx_d;
    logic [RA_W-1:0]      reg_addr_q, reg_addr_d;
    logic [MA_W-1:0]      mem_addr_q, mem_addr_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 imem_we_q, imem_we_d;
    logic [IA_W-1:0]      imem_addr_q, imem_addr_d;
    logic [WORD_BITS-1:0] imem_data_q, imem_data_d;
    logic                 bp_hit;

    // skip masks the breakpoint for the first cycle after resuming at the breakpoint PC
    assign bp_hit = bp_valid_q && (i_mips_pc == brk_addr_q) && !skip_q;

    assign o_mips_enable = ((state_q == S_RUN) && !i_mips_halt && !bp_hit) ||
                           (state_q == S_STEP_EXEC);
    assign o_mips_reset  = (state_q == S_IDLE) || (state_q == S_LOAD_LEN) ||
                           (state_q == S_LOAD_DATA) || (state_q == S_BRK_DATA);
    assign o_state         = state_q;
    assign o_tx_start      = tx_start_q;
    assign o_tx_data       = tx_data_q;
    assign o_imem_we       = imem_we_q;
    assign o_imem_addr     = imem_addr_q;
    assign o_imem_data     = imem_data_q;
    assign o_mips_reg_addr = reg_addr_q;
    assign o_mips_mem_addr = mem_addr_q;

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sh_d        = sh_q;
        brk_addr_d  = brk_addr_q;
        bp_valid_d  = bp_valid_q;
        skip_d      = skip_q;
        halt_stop_d = halt_stop_q;
        rd_phase_d  = rd_phase_q;
        wait_ign_d  = wait_ign_q;
        widx_d      = widx_q;
        reg_addr_d  = reg_addr_q;
        mem_addr_d  = mem_addr_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        // address advances the cycle after its write strobe
        if (imem_we_q)
            imem_addr_d = (imem_addr_q == IA_W'(IMEM_WORDS - 1)) ? '0 : imem_addr_q + 1'b1;
        case (state_q)
            S_IDLE: if (i_rx_valid) begin
                case (i_rx_data)
                    CMD_R: begin state_d = S_RUN; skip_d = 1'b0; end
                    CMD_S: state_d = S_PAUSE;
                    CMD_L: state_d = S_LOAD_LEN;
                    CMD_B: begin state_d = S_BRK_DATA; bcnt_d = '0; end
                    CMD_C: bp_valid_d = 1'b0;
                    default: ;
                endcase
            end
            S_LOAD_LEN: if (i_rx_valid) begin
                len_d = i_rx_data;
                if (i_rx_data == '0) begin
                    state_d = S_IDLE;
                end else begin
                    bcnt_d      = '0;
                    cnt_d       = '0;
                    imem_addr_d = '0;
                    state_d     = S_LOAD_DATA;
                end
            end
            S_LOAD_DATA: if (i_rx_valid) begin
                sh_d = (sh_q << DATA_BITS) | WORD_BITS'(i_rx_data);
                if (bcnt_q == BC_LAST) begin
                    bcnt_d      = '0;
                    imem_we_d   = 1'b1;
                    imem_data_d = sh_d;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == len_q) state_d = S_IDLE;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            S_BRK_DATA: if (i_rx_valid) begin
                brk_addr_d = (brk_addr_q << DATA_BITS) | WORD_BITS'(i_rx_data);
                if (bcnt_q == BC_LAST) begin
                    bp_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (i_mips_halt || bp_hit) begin
                    halt_stop_d = i_mips_halt;
                    widx_d      = '0;
                    reg_addr_d  = '0;
                    mem_addr_d  = '0;
                    rd_phase_d  = 1'b0;
                    state_d     = S_DUMP_READ;
                end else begin
                    skip_d = 1'b0;
                end
            end
            S_PAUSE: if (i_rx_valid) begin
                case (i_rx_data)
                    CMD_N: state_d = S_STEP_EXEC;
                    CMD_R: begin state_d = S_RUN; skip_d = 1'b1; end
                    CMD_Q: state_d = S_IDLE;
                    default: ;
                endcase
            end
            S_STEP_EXEC: begin
                halt_stop_d = 1'b0;
                widx_d      = '0;
                reg_addr_d  = '0;
                mem_addr_d  = '0;
                rd_phase_d  = 1'b0;
                state_d     = S_DUMP_READ;
            end
            S_DUMP_READ: begin
                // first cycle lets the register/memory read data settle
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rd_phase_d = 1'b0;
                    bcnt_d     = '0;
                    state_d    = S_DUMP_TX;
                    if (widx_q == '0)              sh_d = i_mips_pc;
                    else if (widx_q == WI_W'(1))   sh_d = i_mips_cycles;
                    else if (widx_q < MEM_LO)      sh_d = i_mips_reg_data;
                    else                           sh_d = i_mips_mem_data;
                end
            end
            S_DUMP_TX: if (!i_tx_busy) begin
                tx_start_d = 1'b1;
                tx_data_d  = sh_q[WORD_BITS-1 -: DATA_BITS];
                wait_ign_d = 1'b1;
                state_d    = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (wait_ign_q) begin
                    wait_ign_d = 1'b0;
                end else if (!i_tx_busy) begin
                    if (bcnt_q != BC_LAST) begin
                        sh_d    = sh_q << DATA_BITS;
                        bcnt_d  = bcnt_q + 1'b1;
                        state_d = S_DUMP_TX;
                    end else if (widx_q == WI_LAST) begin
                        state_d = halt_stop_q ? S_IDLE : S_PAUSE;
                    end else begin
                        widx_d  = widx_q + 1'b1;
                        if (widx_q >= REG_LO && widx_q < REG_HI) reg_addr_d = reg_addr_q + 1'b1;
                        if (widx_q >= MEM_LO) mem_addr_d = mem_addr_q + 1'b1;
                        state_d = S_DUMP_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bcnt_q      <= '0;
            cnt_q       <= '0;
            bp_valid_q  <= 1'b0;
            skip_q      <= 1'b0;
            halt_stop_q <= 1'b0;
            rd_phase_q  <= 1'b0;
            wait_ign_q  <= 1'b0;
            widx_q      <= '0;
            reg_addr_q  <= '0;
            mem_addr_q  <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            cnt_q       <= cnt_d;
            bp_valid_q  <= bp_valid_d;
            skip_q      <= skip_d;
            halt_stop_q <= halt_stop_d;
            rd_phase_q  <= rd_phase_d;
            wait_ign_q  <= wait_ign_d;
            widx_q      <= widx_d;
            reg_addr_q  <= reg_addr_d;
            mem_addr_q  <= mem_addr_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q      <= len_d;
        sh_q       <= sh_d;
        brk_addr_q <= brk_addr_d;
    end
endmodule

// File: tb/tb_mips_debug_controller.sv
// Bench for mips_debug_controller: behavioural MIPS/UART environment, a default 32-bit
// build and a 16-bit build, with dumps checked against expected byte streams.
module tb_mips_debug_controller;
    localparam int RC = 32, MW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_start, mips_en, mips_rst, imem_we;
    logic [7:0]  tx_data;
    logic [4:0]  reg_addr;
    logic [3:0]  mem_addr, state;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_m = 0, cyc_m = 0, reg_rd = 0, mem_rd = 0, halt_at = 0;
    logic [31:0] regs [RC];
    logic [31:0] mems [MW];
    bit          halt_on = 1'b0, force_busy = 1'b0;
    logic        halt1, tx_busy;
    int          busy_cnt = 0, viol = 0, en_pulses = 0, tick = 0, last_start = -10;
    logic [7:0]  txq[$];
    logic [7:0]  exp_q[$];
    logic [5:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          total = 0, bad = 0;

    assign halt1   = halt_on && (cyc_m >= halt_at);
    assign tx_busy = (busy_cnt > 0) || force_busy;

    mips_debug_controller dut (
        .clk(clk), .reset(reset), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .i_tx_busy(tx_busy), .o_tx_start(tx_start), .o_tx_data(tx_data),
        .i_mips_halt(halt1), .i_mips_pc(pc_m), .i_mips_cycles(cyc_m),
        .i_mips_reg_data(reg_rd), .i_mips_mem_data(mem_rd),
        .o_mips_reg_addr(reg_addr), .o_mips_mem_addr(mem_addr),
        .o_mips_enable(mips_en), .o_mips_reset(mips_rst), .o_imem_we(imem_we),
        .o_imem_addr(imem_addr), .o_imem_data(imem_data), .o_state(state)
    );

    // Behavioural MIPS core and UART transmitter for the 32-bit build
    always @(posedge clk) begin
        tick <= tick + 1;
        if (mips_rst) begin pc_m <= 0; cyc_m <= 0; end
        else if (mips_en) begin pc_m <= pc_m + 4; cyc_m <= cyc_m + 1; end
        if (mips_en) en_pulses <= en_pulses + 1;
        reg_rd <= regs[reg_addr];
        mem_rd <= mems[mem_addr];
        if (tx_start) begin
            if (tx_busy) viol <= viol + 1;
            if (tick - last_start < 2) viol <= viol + 1;
            last_start <= tick;
            txq.push_back(tx_data);
            busy_cnt <= int'($urandom_range(1, 4));
        end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (imem_we) begin wa_q.push_back(imem_addr); wd_q.push_back(imem_data); end
    end

    // 16-bit build: halt is permanently asserted, so 'r' stops immediately
    logic        rx_valid2 = 1'b0;
    logic [7:0]  rx_data2 = 8'h00;
    logic        tx_start2, en2, rst2, we2;
    logic [7:0]  tx_data2;
    logic [1:0]  reg_addr2, mem_addr2;
    logic [3:0]  imem_addr2, state2;
    logic [15:0] imem_data2, pc2, cyc2, reg_rd2 = 0, mem_rd2 = 0;
    logic [15:0] regs2 [4];
    logic [15:0] mems2 [4];
    int          busy2_cnt = 0, en2_pulses = 0;
    logic        busy2;
    logic [7:0]  q2[$];
    assign busy2 = busy2_cnt > 0;

    mips_debug_controller #(.DATA_BITS(8), .WORD_BITS(16), .REG_COUNT(4),
                            .MEM_WORDS(4), .IMEM_WORDS(16)) dut16 (
        .clk(clk), .reset(reset), .i_rx_valid(rx_valid2), .i_rx_data(rx_data2),
        .i_tx_busy(busy2), .o_tx_start(tx_start2), .o_tx_data(tx_data2),
        .i_mips_halt(1'b1), .i_mips_pc(pc2), .i_mips_cycles(cyc2),
        .i_mips_reg_data(reg_rd2), .i_mips_mem_data(mem_rd2),
        .o_mips_reg_addr(reg_addr2), .o_mips_mem_addr(mem_addr2),
        .o_mips_enable(en2), .o_mips_reset(rst2), .o_imem_we(we2),
        .o_imem_addr(imem_addr2), .o_imem_data(imem_data2), .o_state(state2)
    );

    always @(posedge clk) begin
        reg_rd2 <= regs2[reg_addr2];
        mem_rd2 <= mems2[mem_addr2];
        if (en2) en2_pulses <= en2_pulses + 1;
        if (tx_start2) begin
            if (busy2) viol <= viol + 1;
            q2.push_back(tx_data2);
            busy2_cnt <= 2;
        end else if (busy2_cnt > 0) busy2_cnt <= busy2_cnt - 1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    function automatic bit in_dump();
        return state >= 4'd7 && state <= 4'd9;
    endfunction

    task automatic wait_dump(input int n, output bit ok);
        int k = 0;
        while ((txq.size() < n || in_dump()) && k < 8000) begin @(negedge clk); k++; end
        ok = (txq.size() == n) && !in_dump();
    endtask

    // Expected stream: PC, cycles, all registers, all memory words, MSB first
    task automatic fill_exp(input logic [31:0] pc, input logic [31:0] cyc);
        logic [31:0] w [$];
        exp_q.delete();
        w.push_back(pc); w.push_back(cyc);
        for (int i = 0; i < RC; i++) w.push_back(regs[i]);
        for (int i = 0; i < MW; i++) w.push_back(mems[i]);
        foreach (w[i]) for (int b = 3; b >= 0; b--) exp_q.push_back(8'(w[i] >> (8 * b)));
    endtask

    function automatic int first_diff();
        int n = (txq.size() < exp_q.size()) ? txq.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (txq[i] !== exp_q[i]) return i;
        if (txq.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] got_at(input int i);
        return (i >= 0 && i < txq.size()) ? txq[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'hxx;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (mips_rst !== 1'b1) begin bad++; $display("FAIL rst_mips_reset got=%b want=1", mips_rst); end
        total++; if (mips_en !== 1'b0) begin bad++; $display("FAIL rst_enable got=%b want=0", mips_en); end
        total++; if (tx_start !== 1'b0 || imem_we !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b want=00", tx_start, imem_we); end
        total++; if (state !== 4'd0 || tx_data !== 8'h00 || imem_addr !== 6'd0) begin
            bad++; $display("FAIL rst_state got=%0d/%h/%0d want=0/00/0", state, tx_data, imem_addr); end
    endtask

    task automatic test_load();
        logic [31:0] w [3];
        logic [7:0]  fixed [9];
        fixed = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        send_byte(8'h6C);
        foreach (fixed[i]) send_byte(fixed[i]);
        repeat (3) @(negedge clk);
        total++; if (wa_q.size() != 2) begin bad++; $display("FAIL load_count got=%0d want=2", wa_q.size()); end
        else begin
            total++; if (wa_q[0] !== 6'd0 || wd_q[0] !== 32'h8C010004) begin
                bad++; $display("FAIL load_w0 got=%0d:%h want=0:8c010004", wa_q[0], wd_q[0]); end
            total++; if (wa_q[1] !== 6'd1 || wd_q[1] !== 32'h0) begin
                bad++; $display("FAIL load_w1 got=%0d:%h want=1:00000000", wa_q[1], wd_q[1]); end
        end
        total++; if (state !== 4'd0) begin bad++; $display("FAIL load_idle got=%0d want=0", state); end
        wa_q.delete(); wd_q.delete();
        foreach (w[i]) w[i] = $urandom;
        send_byte(8'h6C); send_byte(8'h03);
        foreach (w[i]) for (int b = 3; b >= 0; b--) send_byte(8'(w[i] >> (8 * b)));
        repeat (3) @(negedge clk);
        total++; if (wa_q.size() != 3) begin bad++; $display("FAIL load_rand_count got=%0d want=3", wa_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            total++; if (wa_q[i] !== 6'(i) || wd_q[i] !== w[i]) begin
                bad++; $display("FAIL load_rand_w%0d got=%0d:%h want=%0d:%h", i, wa_q[i], wd_q[i], i, w[i]); end
        end
    endtask

    task automatic test_breakpoint();
        bit ok; int d;
        txq.delete();
        send_byte(8'h62);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        send_byte(8'h72);
        wait_dump(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_dump_len got=%0d want=200 state=%0d", txq.size(), state); end
        fill_exp(32'd8, 32'd2);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL bp_dump idx=%0d got=%h want=%h", d, got_at(d), exp_at(d)); end
        total++; if (pc_m !== 32'd8) begin bad++; $display("FAIL bp_pc got=%0d want=8", pc_m); end
        @(negedge clk);
        total++; if (state !== 4'd5) begin bad++; $display("FAIL bp_pause got=%0d want=5", state); end
        send_byte(8'h72);
        repeat (6) @(negedge clk);
        total++; if (pc_m <= 32'd8) begin bad++; $display("FAIL bp_resume got=%0d want>8", pc_m); end
        txq.delete();
        halt_at = 0; halt_on = 1'b1;
        wait_dump(200, ok);
        @(negedge clk);
        total++; if (!ok || state !== 4'd0 || mips_rst !== 1'b1) begin
            bad++; $display("FAIL bp_exit got=%0d/%0d/%b want=200/0/1", txq.size(), state, mips_rst); end
        halt_on = 1'b0;
        send_byte(8'h63);
    endtask

    task automatic test_step();
        bit ok; int d, e0;
        send_byte(8'h73);
        for (int s = 1; s <= 2; s++) begin
            txq.delete();
            e0 = en_pulses;
            send_byte(8'h6E);
            wait_dump(200, ok);
            total++; if (!ok || en_pulses - e0 != 1) begin
                bad++; $display("FAIL step%0d got=%0d bytes %0d pulses want=200 bytes 1 pulse", s, txq.size(), en_pulses - e0); end
            fill_exp(32'(4 * s), 32'(s));
            d = first_diff();
            total++; if (d != -1) begin bad++; $display("FAIL step%0d_dump idx=%0d got=%h want=%h", s, d, got_at(d), exp_at(d)); end
        end
        @(negedge clk);
        total++; if (state !== 4'd5) begin bad++; $display("FAIL step_pause got=%0d want=5", state); end
        send_byte(8'h71);
        total++; if (state !== 4'd0) begin bad++; $display("FAIL step_quit got=%0d want=0", state); end
    endtask

    task automatic test_halt();
        bit ok; int d, k;
        txq.delete();
        halt_at = 10; halt_on = 1'b1;
        send_byte(8'h72);
        k = 0;
        while (txq.size() < 20 && k < 2000) begin @(negedge clk); k++; end
        send_byte(8'h78); send_byte(8'h72); send_byte(8'h73);
        wait_dump(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL halt_dump_len got=%0d want=200", txq.size()); end
        fill_exp(32'd40, 32'd10);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL halt_dump idx=%0d got=%h want=%h", d, got_at(d), exp_at(d)); end
        total++; if (state !== 4'd0 || mips_rst !== 1'b1) begin
            bad++; $display("FAIL halt_idle got=%0d/%b want=0/1", state, mips_rst); end
        halt_on = 1'b0;
    endtask

    task automatic test_busy_hold();
        bit ok; int d, s0, k;
        txq.delete();
        send_byte(8'h73); send_byte(8'h6E);
        k = 0;
        while (!(busy_cnt > 0 && txq.size() >= 30) && k < 3000) begin @(negedge clk); k++; end
        force_busy = 1'b1;
        s0 = txq.size();
        repeat (50) @(negedge clk);
        total++; if (txq.size() != s0) begin bad++; $display("FAIL busy_hold got=%0d starts want=0", txq.size() - s0); end
        force_busy = 1'b0;
        wait_dump(200, ok);
        fill_exp(32'd4, 32'd1);
        d = first_diff();
        total++; if (!ok || d != -1) begin bad++; $display("FAIL busy_dump idx=%0d got=%h want=%h", d, got_at(d), exp_at(d)); end
        send_byte(8'h71);
    endtask

    task automatic test_wide();
        logic [7:0]  e2[$];
        logic [15:0] w [$];
        int k, d;
        w.push_back(pc2); w.push_back(cyc2);
        foreach (regs2[i]) w.push_back(regs2[i]);
        foreach (mems2[i]) w.push_back(mems2[i]);
        foreach (w[i]) begin e2.push_back(w[i][15:8]); e2.push_back(w[i][7:0]); end
        @(negedge clk); rx_valid2 = 1'b1; rx_data2 = 8'h72;
        @(negedge clk); rx_valid2 = 1'b0;
        k = 0;
        while (!(q2.size() >= 20 && state2 == 4'd0) && k < 3000) begin @(negedge clk); k++; end
        d = -1;
        for (int i = 0; i < 20 && d == -1; i++) if (i >= q2.size() || q2[i] !== e2[i]) d = i;
        total++; if (d != -1 || q2.size() != 20) begin
            bad++; $display("FAIL wide_dump idx=%0d len=%0d want_len=20 want=%h", d, q2.size(), (d >= 0) ? e2[d] : 8'h00); end
        total++; if (en2_pulses != 0 || rst2 !== 1'b1) begin
            bad++; $display("FAIL wide_enable got=%0d/%b want=0/1", en2_pulses, rst2); end
    endtask

    task automatic test_reset_abort();
        int k = 0;
        txq.delete();
        send_byte(8'h73); send_byte(8'h6E);
        while (txq.size() < 10 && k < 2000) begin @(negedge clk); k++; end
        reset = 1'b1;
        #1;
        total++; if (state !== 4'd0 || mips_rst !== 1'b1 || tx_start !== 1'b0 || mips_en !== 1'b0) begin
            bad++; $display("FAIL reset_abort got=%0d/%b/%b/%b want=0/1/0/0", state, mips_rst, tx_start, mips_en); end
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (viol != 0) begin bad++; $display("FAIL tx_protocol got=%0d violations want=0", viol); end
    endtask

    initial begin
        foreach (regs[i]) regs[i] = $urandom;
        foreach (mems[i]) mems[i] = $urandom;
        foreach (regs2[i]) regs2[i] = 16'($urandom);
        foreach (mems2[i]) mems2[i] = 16'($urandom);
        pc2 = 16'($urandom); cyc2 = 16'($urandom);
        test_reset();
        test_load();
        test_breakpoint();
        test_step();
        test_halt();
        test_busy_hold();
        test_wide();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
